// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed wait-state response protocol.
// Accesses are captured in IDLE, optionally stall in WAIT, and complete in a one-cycle RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             rd_q;
  logic             wr_q;
  logic             err_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             req;
  logic             addr_ok;
  logic             req_legal;
  logic [IDX_W-1:0] req_idx;

  // Handshake: MemRead/MemWrite act as a request that is sampled only in IDLE.
  // Ready pulses for one cycle when the access completes; the requester must drop
  // its request after seeing Ready, otherwise the following IDLE cycle accepts it again.
  assign req       = MemRead | MemWrite;
  assign addr_ok   = (Addr[1:0] == 2'b00) && ((Addr >> (IDX_W + 2)) == 32'd0);
  assign req_legal = addr_ok && !(MemRead && MemWrite);
  assign req_idx   = Addr[IDX_W+1:2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      ReadData <= 32'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q   <= req_idx;
            wdata_q <= WriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= !req_legal;
            // Rejected accesses and zero-wait configurations respond immediately.
            if (!req_legal || WAIT_CYCLES == 0) begin
              state <= S_RESP;
              if (req_legal && MemRead) ReadData <= mem[req_idx];
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
            if (rd_q) ReadData <= mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is never cleared; a reset during RESP suppresses the pending write.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_RESP && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign Busy      = (state != S_IDLE);
  assign Ready     = (state == S_RESP);
  assign AddrErr   = (state == S_RESP) && err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level memory model,
// with a second instance configured for zero wait states.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;
  localparam int LAT   = W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mr, mw;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy, aerr;
  logic [1:0]  st;

  logic        mr0, mw0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, busy0, aerr0;
  logic [1:0]  st0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .CLK(clk), .RST(rst), .MemRead(mr), .MemWrite(mw), .Addr(addr), .WriteData(wdata),
    .ReadData(rdata), .Ready(ready), .Busy(busy), .AddrErr(aerr), .dbg_state(st)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RST(rst), .MemRead(mr0), .MemWrite(mw0), .Addr(addr0), .WriteData(wdata0),
    .ReadData(rdata0), .Ready(ready0), .Busy(busy0), .AddrErr(aerr0), .dbg_state(st0)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [DEPTH];
  bit          vld_m [DEPTH];
  logic [31:0] rd_m;
  logic [31:0] exp_q [$];
  int          written_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic rd, input logic wr, input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(DEPTH * 4)) && !(rd && wr);
  endfunction

  // Drives one access from a negedge and checks every cycle up to the following IDLE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit legal;
    int lat;
    int idx;
    legal = is_legal(rd, wr, a);
    lat   = legal ? LAT : 1;
    idx   = legal ? int'(a / 4) : 0;
    if (legal && rd) exp_q.push_back(mem_m[idx]);
    mr = rd; mw = wr; addr = a; wdata = d;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == lat && legal && rd) rd_m = exp_q.pop_front();
      check_eq("busy",    32'(busy),  32'(c <= lat));
      check_eq("ready",   32'(ready), 32'(c == lat));
      check_eq("addrerr", 32'(aerr),  32'(c == lat && !legal));
      check_eq("rdata",   rdata,      rd_m);
      if (c < lat) begin
        mr    = 1'($urandom_range(0, 1));
        mw    = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
      end else if (c == lat) begin
        mr = 1'b0; mw = 1'b0; addr = 32'd0; wdata = 32'd0;
      end
    end
    if (legal && wr) begin
      mem_m[idx] = d;
      if (!vld_m[idx]) begin
        vld_m[idx] = 1'b1;
        written_q.push_back(idx);
      end
    end
  endtask

  task automatic random_access();
    int          r;
    logic [31:0] a, d, tmp;
    r = int'($urandom_range(0, 9));
    d = $urandom;
    if (r <= 3) begin
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      access(1'b0, 1'b1, a, d);
    end else if (r <= 6) begin
      a = 32'(written_q[$urandom_range(0, written_q.size() - 1)] * 4);
      access(1'b1, 1'b0, a, 32'd0);
    end else if (r == 7) begin
      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) access(1'b1, 1'b0, a, d);
      else access(1'b0, 1'b1, a, d);
    end else if (r == 8) begin
      tmp = $urandom;
      a   = (tmp & 32'hFFFF_FFFC) | 32'h0000_0400;
      if ($urandom_range(0, 1) == 1) access(1'b1, 1'b0, a, d);
      else access(1'b0, 1'b1, a, d);
    end else begin
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      access(1'b1, 1'b1, a, d);
    end
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1;
    mr = 1'b1; mw = 1'b0; addr = 32'h10; wdata = 32'd0;
    mr0 = 1'b0; mw0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    rd_m = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_aerr",  32'(aerr), 32'd0);
    rst = 1'b0; mr = 1'b0; addr = 32'd0;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // write then read
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'd0);
    check_eq("wr_rd_data", rdata, 32'hDEAD_BEEF);
    // misaligned read leaves ReadData alone
    access(1'b1, 1'b0, 32'h13, 32'd0);
    // out-of-range write must not alias onto word 0
    access(1'b0, 1'b1, 32'h0, 32'h0000_AAAA);
    access(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF);
    access(1'b1, 1'b0, 32'h0, 32'd0);
    check_eq("no_alias", rdata, 32'h0000_AAAA);
    // read/write conflict
    access(1'b0, 1'b1, 32'h8, 32'h0808_0808);
    access(1'b1, 1'b1, 32'h8, 32'h5555_5555);
    access(1'b1, 1'b0, 32'h8, 32'd0);

    // reset in the middle of a write
    access(1'b0, 1'b1, 32'h20, 32'h1);
    access(1'b1, 1'b0, 32'h20, 32'd0);
    mr = 1'b0; mw = 1'b1; addr = 32'h20; wdata = 32'h1234;
    @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; mw = 1'b0; mr = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rdata", rdata, 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd0);
    check_eq("mid_rst_busy",  32'(busy), 32'd0);
    check_eq("mid_rst_aerr",  32'(aerr), 32'd0);
    @(negedge clk);
    check_eq("rst_held_req_busy", 32'(busy), 32'd0);
    rst = 1'b0; mr = 1'b0; addr = 32'd0;
    rd_m = 32'd0;
    @(negedge clk);
    check_eq("after_rst_busy", 32'(busy), 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'd0);
    check_eq("aborted_write", rdata, 32'h1);

    repeat (150) random_access();

    // zero wait states: back-to-back reads with the request held high
    mw0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h5A5A_0004;
    @(negedge clk);
    check_eq("z_wr_ready", 32'(ready0), 32'd1);
    check_eq("z_wr_busy",  32'(busy0), 32'd1);
    check_eq("z_wr_aerr",  32'(aerr0), 32'd0);
    mw0 = 1'b0;
    @(negedge clk);
    check_eq("z_idle_busy", 32'(busy0), 32'd0);
    mr0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_eq("z_ready", 32'(ready0), 32'(k % 2 == 1));
      check_eq("z_busy",  32'(busy0),  32'(k % 2 == 1));
      check_eq("z_aerr",  32'(aerr0),  32'd0);
      if (k % 2 == 1) check_eq("z_rdata", rdata0, 32'h5A5A_0004);
    end
    mr0 = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles per legal access; the legal range SHALL be 0..15.
REQ-003 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 MemRead  in  1  load request from the datapath.
REQ-006 MemWrite  in  1  store request from the datapath.
REQ-007 Addr  in  32  byte address (the datapath ALU result).
REQ-008 WriteData  in  32  store data (the datapath register-file second read port).
REQ-009 ReadData  out  32  registered load data.
REQ-010 Ready  out  1  one-cycle pulse marking access completion.
REQ-011 Busy  out  1  high while an access is in progress.
REQ-012 AddrErr  out  1  one-cycle pulse, coincident with Ready, marking a rejected access.

Function
REQ-013 Storage SHALL be DEPTH_WORDS x 32 bits, word index = Addr[31:2].
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 Requests SHALL be sampled only in IDLE; request inputs in WAIT or RESP SHALL be ignored.
REQ-016 On acceptance in IDLE, Addr, WriteData and the operation SHALL be captured into internal registers; later input changes SHALL have no effect on the access.
REQ-017 A request SHALL be illegal if any of these holds: Addr[1:0] != 0; Addr[31:2] >= DEPTH_WORDS; both MemRead and MemWrite are high.
REQ-018 For a legal request accepted at the end of cycle 0:
- WAIT_CYCLES > 0: state WAIT for cycles 1..WAIT_CYCLES, with the wait counter counting down to 0, then RESP in cycle WAIT_CYCLES+1.
- WAIT_CYCLES = 0: RESP in cycle 1.
REQ-019 For an illegal request, IDLE SHALL go directly to RESP in the next cycle with no wait states.
REQ-020 In RESP, Ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-021 Busy SHALL be 1 exactly when state is WAIT or RESP; it SHALL be driven from state only, not from the request inputs.
REQ-022 Legal read: ReadData SHALL show mem[captured index] during the RESP cycle.
REQ-023 Legal write: the memory word SHALL be updated at the rising edge ending the RESP cycle; no partial or byte writes are supported.
REQ-024 ReadData SHALL hold its last read value through writes, errors and idle cycles.
REQ-025 Illegal access: AddrErr = 1 in the RESP cycle, memory unchanged, ReadData unchanged.
REQ-026 Minimum spacing between Ready pulses SHALL be WAIT_CYCLES+2 cycles, because one IDLE cycle always separates accesses.
REQ-027 A request still held high in the IDLE cycle after RESP SHALL be treated as a new access; the requester SHALL deassert after seeing Ready.
REQ-028 A read of a word not yet written SHALL return the storage's unreset contents; the bench SHALL treat these as don't-care.

Reset
REQ-029 While RST = 1 at a rising edge, the block SHALL load: state IDLE, wait counter 0, ReadData 0x00000000, Ready 0, Busy 0, AddrErr 0.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 RST SHALL take priority over all other activity; an access in WAIT or RESP SHALL be aborted and its pending write SHALL NOT be committed.
REQ-032 A request held during the reset cycle SHALL NOT be accepted; sampling SHALL begin in the first cycle after RST deasserts.

Verification (DEPTH_WORDS = 256, WAIT_CYCLES = 2 unless stated)
REQ-033 Write then read: MemWrite, Addr 0x10, WriteData 0xDEADBEEF, then MemRead, Addr 0x10 -> Ready in cycle 3 of each access, Busy high cycles 1-3, ReadData = 0xDEADBEEF at the read Ready, AddrErr stays 0.
REQ-034 Misaligned read: MemRead, Addr 0x13 -> cycle 1 has Ready = 1 and AddrErr = 1, Busy high for 1 cycle only, ReadData unchanged.
REQ-035 Out-of-range write: MemWrite, Addr 0x400, data 0xFFFFFFFF, after word 0 = 0x0000AAAA -> AddrErr pulse; a subsequent read of 0x0 returns 0x0000AAAA (no aliasing).
REQ-036 Reset mid-write: mem[0x20] = 0x1; MemWrite to 0x20 with data 0x1234; RST asserted in WAIT cycle 1 -> all outputs 0 next cycle, no Ready pulse; a later read of 0x20 returns 0x1.
REQ-037 Conflict: MemRead = MemWrite = 1, Addr 0x8 -> AddrErr = 1 in cycle 1, mem[0x8] unchanged.
REQ-038 Zero wait states (WAIT_CYCLES = 0): MemRead held high continuously at Addr 0x4 -> Ready in cycles 1, 3, 5, ..., Busy alternating 0/1.
